// File: rtl/lsm_pv_accumulator.sv
// Batch accumulator for discounted path values: produces the mean and the mean
// square of every N = 2^LOG2_N accepted samples, with a valid/ready result handshake.
module lsm_pv_accumulator #(
   parameter int WIDTH  = 32,
   parameter int QINT   = 16,
   parameter int QFRAC  = 16,
   parameter int LOG2_N = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_in,
   output logic                    ready_out,
   input  logic signed [WIDTH-1:0] PV,
   output logic                    valid_out,
   input  logic                    ready_in,
   output logic signed [WIDTH-1:0] mean,
   output logic        [WIDTH-1:0] mean_sq,
   output logic        [15:0]      batch_cnt
);

   localparam int SUM_W = WIDTH + LOG2_N;
   localparam int SQ_W  = 2 * WIDTH + LOG2_N;

   if (QINT + QFRAC != WIDTH) begin : g_bad_q_format
      $error("lsm_pv_accumulator: QINT + QFRAC must equal WIDTH");
   end

   typedef enum logic [1:0] {ACCUM, FINAL, DONE} state_t;

   state_t                   state;
   logic signed [SUM_W-1:0]  sum;
   logic signed [SQ_W-1:0]   sumsq;
   logic        [LOG2_N-1:0] count;

   logic signed [SQ_W-1:0]   pv_wide;
   logic signed [SQ_W-1:0]   pv_sq;
   logic signed [SQ_W-1:0]   sq_term;
   logic                     sq_sat;

   // The square is formed at full accumulator width so the sign-extended
   // operand alone carries the product; it can never exceed 2*WIDTH bits.
   assign pv_wide = {{(SQ_W-WIDTH){PV[WIDTH-1]}}, PV};
   assign pv_sq   = pv_wide * pv_wide;
   assign sq_term = pv_sq >>> QFRAC;

   // sumsq is never negative, so any set bit at or above the top result bit
   // (after dividing by N) means the mean square exceeds the largest positive word.
   assign sq_sat = |sumsq[SQ_W-1:LOG2_N+WIDTH-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ACCUM;
         ready_out <= 1'b1;
         valid_out <= 1'b0;
         mean      <= '0;
         mean_sq   <= '0;
         batch_cnt <= '0;
         sum       <= '0;
         sumsq     <= '0;
         count     <= '0;
      end else begin
         case (state)
            ACCUM: begin
               if (valid_in) begin
                  sum   <= sum + pv_wide[SUM_W-1:0];
                  sumsq <= sumsq + sq_term;
                  count <= count + 1'b1;
                  if (&count) begin
                     state     <= FINAL;
                     ready_out <= 1'b0;
                  end
               end
            end
            FINAL: begin
               mean      <= sum[SUM_W-1:LOG2_N];
               mean_sq   <= sq_sat ? {1'b0, {(WIDTH-1){1'b1}}} : sumsq[LOG2_N +: WIDTH];
               valid_out <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (ready_in) begin
                  valid_out <= 1'b0;
                  sum       <= '0;
                  sumsq     <= '0;
                  batch_cnt <= batch_cnt + 16'd1;
                  ready_out <= 1'b1;
                  state     <= ACCUM;
               end
            end
            default: begin
               state     <= ACCUM;
               ready_out <= 1'b1;
               valid_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsm_pv_accumulator.sv
// Scoreboard bench for lsm_pv_accumulator with N = 4: a reference model predicts
// each batch result from accepted samples; a monitor compares at every output transfer.
module tb_lsm_pv_accumulator;

   localparam int WIDTH  = 32;
   localparam int QINT   = 16;
   localparam int QFRAC  = 16;
   localparam int LOG2_N = 2;
   localparam int N      = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              valid_in = 1'b0;
   logic              ready_out;
   logic [WIDTH-1:0]  pv = '0;
   logic              valid_out;
   logic              ready_in = 1'b0;
   logic [WIDTH-1:0]  mean;
   logic [WIDTH-1:0]  mean_sq;
   logic [15:0]       batch_cnt;

   typedef struct {
      logic [31:0] mean;
      logic [31:0] mean_sq;
      logic [15:0] batch;
   } result_t;

   result_t exp_q[$];
   longint  batch_q[$];
   int      model_batches = 0;
   int      pass_cnt = 0;
   int      check_cnt = 0;
   int      ready_mode = 0;
   int      lat_stage = 0;
   int      transfers = 0;

   lsm_pv_accumulator #(
      .WIDTH(WIDTH), .QINT(QINT), .QFRAC(QFRAC), .LOG2_N(LOG2_N)
   ) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
      .PV(pv), .valid_out(valid_out), .ready_in(ready_in),
      .mean(mean), .mean_sq(mean_sq), .batch_cnt(batch_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input longint actual, input longint expected);
      check_cnt++;
      if (actual == expected) pass_cnt++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic report_timeout(input string name);
      check_cnt++;
      $display("[TB] FAIL %s: timed out waiting on the DUT", name);
   endtask

   function automatic longint floor_div(input longint a, input longint b);
      longint q = a / b;
      if ((a % b != 0) && ((a < 0) != (b < 0))) q--;
      return q;
   endfunction

   // Reference model: a batch result is the floored mean of the samples and the
   // mean of their squares (each square scaled down by 2^QFRAC), clamped positive.
   function automatic void model_accept(input logic [31:0] v);
      longint  s = 0;
      longint  sq = 0;
      longint  m;
      result_t r;
      batch_q.push_back(longint'(signed'(v)));
      if (batch_q.size() == N) begin
         foreach (batch_q[i]) begin
            s  += batch_q[i];
            sq += (batch_q[i] * batch_q[i]) / (longint'(1) << QFRAC);
         end
         m         = sq / N;
         r.mean    = 32'(floor_div(s, N));
         r.mean_sq = (m > 64'sh7FFF_FFFF) ? 32'h7FFF_FFFF : 32'(m);
         r.batch   = 16'(model_batches);
         model_batches++;
         exp_q.push_back(r);
         batch_q.delete();
         lat_stage = 3;
      end
   endfunction

   function automatic void model_reset();
      batch_q.delete();
      exp_q.delete();
      model_batches = 0;
   endfunction

   // Offer one sample after a random gap and hold it until the DUT can take it.
   task automatic apply_stimulus(input logic [31:0] v, input int max_gap);
      int gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int t = 0; t < gap + 200; t++) begin
         @(negedge clk);
         if (t < gap) begin
            valid_in = 1'b0;
         end else begin
            valid_in = 1'b1;
            pv       = v;
            if (ready_out) begin
               model_accept(v);
               return;
            end
         end
      end
      report_timeout("accept");
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         valid_in = 1'b0;
      end
   endtask

   task automatic wait_drain(input string name);
      int t = 0;
      while ((exp_q.size() != 0 || valid_out) && t < 300) begin
         @(negedge clk);
         valid_in = 1'b0;
         t++;
      end
      if (t >= 300) report_timeout(name);
      idle(2);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      valid_in = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check_output("reset_valid_out", valid_out, 0);
      check_output("reset_mean", mean, 0);
      check_output("reset_mean_sq", mean_sq, 0);
      check_output("reset_batch_cnt", batch_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check_output("reset_ready_out", ready_out, 1);
   endtask

   initial begin : ready_driver
      forever begin
         @(negedge clk);
         case (ready_mode)
            0:       ready_in = 1'b1;
            1:       ready_in = ($urandom_range(2, 0) != 0);
            default: ready_in = 1'b0;
         endcase
      end
   end

   // Monitor: samples just after each falling edge, so the sampled valid/ready
   // pair is exactly what the next rising edge will act on.
   initial begin : monitor
      logic        stalled = 1'b0;
      logic        post_xfer = 1'b0;
      logic        have_last = 1'b0;
      logic [31:0] held_mean = '0;
      logic [31:0] held_sq = '0;
      result_t     r;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            stalled   = 1'b0;
            post_xfer = 1'b0;
            have_last = 1'b0;
            lat_stage = 0;
            transfers = 0;
            continue;
         end
         if (post_xfer) check_output("ready_after_xfer", ready_out, 1);
         post_xfer = 1'b0;
         if (lat_stage == 3) begin
            lat_stage = 2;
         end else if (lat_stage == 2) begin
            check_output("latency_final_valid", valid_out, 0);
            check_output("latency_final_ready", ready_out, 0);
            lat_stage = 1;
         end else if (lat_stage == 1) begin
            check_output("latency_done_valid", valid_out, 1);
            lat_stage = 0;
         end
         if (stalled) begin
            check_output("stall_valid", valid_out, 1);
            check_output("stall_mean", mean, held_mean);
            check_output("stall_mean_sq", mean_sq, held_sq);
         end
         if (valid_out) begin
            check_output("done_ready_out", ready_out, 0);
         end else if (have_last) begin
            check_output("retain_mean", mean, held_mean);
            check_output("retain_mean_sq", mean_sq, held_sq);
         end
         if (valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
               report_timeout("unexpected_result");
            end else begin
               r = exp_q.pop_front();
               check_output("result_mean", mean, r.mean);
               check_output("result_mean_sq", mean_sq, r.mean_sq);
               check_output("result_batch_cnt", batch_cnt, r.batch);
            end
            have_last = 1'b1;
            post_xfer = 1'b1;
            transfers++;
         end
         stalled   = valid_out && !ready_in;
         held_mean = mean;
         held_sq   = mean_sq;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, check_cnt);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      logic [31:0] v;
      logic [31:0] signs [4];
      int          t;
      #1 rst_n = 1'b0;
      do_reset();

      $display("[TB] unit samples, back to back");
      ready_mode = 0;
      for (int i = 0; i < N; i++) apply_stimulus(32'h0001_0000, 0);
      idle(1);
      wait_drain("drain_unit");
      check_output("unit_batch_cnt", batch_cnt, 1);

      $display("[TB] mixed signs");
      signs = '{32'h0002_0000, 32'hFFFE_0000, 32'h0004_0000, 32'h0000_0000};
      for (int i = 0; i < N; i++) apply_stimulus(signs[i], 1);
      idle(1);
      wait_drain("drain_signs");

      $display("[TB] stalled result with ignored valid_in pulses");
      ready_mode = 2;
      for (int i = 0; i < N; i++) apply_stimulus($urandom, 0);
      idle(1);
      t = 0;
      while (!valid_out && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!valid_out) report_timeout("stall_wait_valid");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         valid_in = (i % 2 == 0);
         pv       = $urandom;
      end
      @(negedge clk);
      valid_in   = 1'b0;
      ready_mode = 0;
      wait_drain("drain_stall");
      check_output("stall_batch_cnt", batch_cnt, 3);

      $display("[TB] positive full-scale samples");
      for (int i = 0; i < N; i++) apply_stimulus(32'h7FFF_FFFF, 0);
      idle(1);
      wait_drain("drain_max");

      $display("[TB] reset mid-batch");
      for (int i = 0; i < 2; i++) apply_stimulus($urandom, 0);
      idle(1);
      do_reset();
      for (int i = 0; i < N; i++) apply_stimulus(32'h0003_0000, 0);
      idle(1);
      wait_drain("drain_after_reset");
      check_output("reset_batch_cnt_after", batch_cnt, 1);

      $display("[TB] random gaps over 8 batches");
      do_reset();
      ready_mode = 1;
      for (int b = 0; b < 8 * N; b++) begin
         v = $urandom;
         if ($urandom_range(1, 0) == 1) v = {{12{v[19]}}, v[19:0]};
         apply_stimulus(v, 3);
      end
      idle(1);
      ready_mode = 0;
      wait_drain("drain_random");
      check_output("random_batch_cnt", batch_cnt, 8);
      check_output("random_transfers", transfers, 8);
      check_output("random_leftover_samples", batch_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
